// File: rtl/wb_load_decode.sv
// Wishbone classic read initiator for the load path: issues one read cycle with
// byte selects, then extracts and sign/zero-extends the addressed lane.
module wb_load_decode #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic [31:0]       addr_i,
   input  logic [2:0]        funct3_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              fault_o,
   output logic [XLEN-1:0]   data_o,
   output logic [29:0]       adr_o,
   output logic [3:0]        sel_o,
   output logic              cyc_o,
   output logic              stb_o,
   output logic              we_o,
   input  logic [XLEN-1:0]   dat_i,
   input  logic              ack_i,
   input  logic              err_i
);

   localparam int unsigned ADR_W  = 30;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned LANE_W = 2;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      BUS        = 2'd1,
      RESP_OK    = 2'd2,
      RESP_FAULT = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADR_W-1:0]    adr_q, adr_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [XLEN-1:0]     data_q, data_d;
   logic                cyc_q, cyc_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                fault_q, fault_d;

   logic                req_legal;
   logic                req_aligned;
   logic [SEL_W-1:0]    req_sel;
   logic                timeout_hit;
   logic [XLEN-1:0]     shifted;
   logic [XLEN-1:0]     load_val;

   // Legality, alignment and lane selects of the incoming request
   always_comb begin : req_classify
      req_legal   = 1'b0;
      req_aligned = 1'b0;
      req_sel     = '0;
      case (funct3_i)
         F3_LB, F3_LBU: begin
            req_legal   = 1'b1;
            req_aligned = 1'b1;
            req_sel     = 4'b0001 << addr_i[1:0];
         end
         F3_LH, F3_LHU: begin
            req_legal   = 1'b1;
            req_aligned = ~addr_i[0];
            req_sel     = addr_i[1] ? 4'b1100 : 4'b0011;
         end
         F3_LW: begin
            req_legal   = 1'b1;
            req_aligned = (addr_i[1:0] == 2'b00);
            req_sel     = 4'b1111;
         end
         default: begin
            req_legal   = 1'b0;
         end
      endcase
   end

   // Lane extraction and extension of the returned bus word
   always_comb begin : load_decode
      shifted  = dat_i >> {lane_q, 3'b000};
      load_val = dat_i;
      case (funct3_q)
         F3_LB:   load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         F3_LBU:  load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
         F3_LH:   load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_LHU:  load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: load_val = dat_i;
      endcase
   end

   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   // State and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin : state_reg
      if (rst_i) begin
         state_q  <= IDLE;
         lane_q   <= '0;
         funct3_q <= '0;
         cnt_q    <= '0;
         adr_q    <= '0;
         sel_q    <= '0;
         data_q   <= '0;
         cyc_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         funct3_q <= funct3_d;
         cnt_q    <= cnt_d;
         adr_q    <= adr_d;
         sel_q    <= sel_d;
         data_q   <= data_d;
         cyc_q    <= cyc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         fault_q  <= fault_d;
      end
   end

   // Next state; err beats ack, ack beats timeout
   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_i) begin
               state_d = (req_legal && req_aligned) ? BUS : RESP_FAULT;
            end
         end
         BUS: begin
            if (err_i) begin
               state_d = RESP_FAULT;
            end else if (ack_i) begin
               state_d = RESP_OK;
            end else if (timeout_hit) begin
               state_d = RESP_FAULT;
            end
         end
         RESP_OK:    state_d = IDLE;
         RESP_FAULT: state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // Next values of the registered datapath and outputs
   always_comb begin : output_logic
      lane_d   = lane_q;
      funct3_d = funct3_q;
      adr_d    = adr_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      data_d   = data_q;

      if ((state_q == IDLE) && req_i) begin
         lane_d   = addr_i[1:0];
         funct3_d = funct3_i;
         adr_d    = addr_i[31:2];
         sel_d    = req_sel;
      end

      if (state_q == BUS) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (state_d == BUS) begin
         cnt_d = '0;
      end

      if ((state_q == BUS) && (state_d == RESP_OK)) begin
         data_d = load_val;
      end else if (state_d == RESP_FAULT) begin
         data_d = '0;
      end

      cyc_d   = (state_d == BUS);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == RESP_OK) || (state_d == RESP_FAULT);
      fault_d = (state_d == RESP_FAULT);
   end

   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign fault_o = fault_q;
   assign data_o  = data_q;
   assign adr_o   = adr_q;
   assign sel_o   = sel_q;
   assign cyc_o   = cyc_q;
   assign stb_o   = cyc_q;
   assign we_o    = 1'b0;

endmodule

// File: tb/tb_wb_load_decode.sv
// Bench for wb_load_decode: directed and randomized loads against an arithmetic
// reference of lane selection, alignment and extension.
module tb_wb_load_decode;

   localparam int unsigned TO = 4;

   logic        clk_i;
   logic        rst_i;
   logic        req_i;
   logic [31:0] addr_i;
   logic [2:0]  funct3_i;
   logic        busy_o;
   logic        done_o;
   logic        fault_o;
   logic [31:0] data_o;
   logic [29:0] adr_o;
   logic [3:0]  sel_o;
   logic        cyc_o;
   logic        stb_o;
   logic        we_o;
   logic [31:0] dat_i;
   logic        ack_i;
   logic        err_i;

   int checks = 0;
   int errors = 0;

   wb_load_decode #(.XLEN(32), .TIMEOUT(TO), .CNT_W(3)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (req_i),
      .addr_i   (addr_i),
      .funct3_i (funct3_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .fault_o  (fault_o),
      .data_o   (data_o),
      .adr_o    (adr_o),
      .sel_o    (sel_o),
      .cyc_o    (cyc_o),
      .stb_o    (stb_o),
      .we_o     (we_o),
      .dat_i    (dat_i),
      .ack_i    (ack_i),
      .err_i    (err_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_legal(input logic [2:0] f3);
      return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
   endfunction

   function automatic int ref_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic [3:0] ref_sel(input logic [2:0] f3, input logic [31:0] addr);
      int size = ref_size(f3);
      int lane = int'(addr % 4);
      return 4'(((1 << size) - 1) << lane);
   endfunction

   function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] dat);
      int          lane = int'(addr % 4);
      logic [31:0] sh   = dat >> (8 * lane);
      logic [31:0] v;
      case (ref_size(f3))
         1: begin
            v = sh % 256;
            if (!f3[2] && v >= 128) v = v - 256;
         end
         2: begin
            v = sh % 65536;
            if (!f3[2] && v >= 32768) v = v - 65536;
         end
         default: v = dat;
      endcase
      return v;
   endfunction

   // One complete load: request, slave response after 'waits' cycles, done check
   task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] dat, input int waits, input bit use_err,
                           input bit both_ack);
      bit          bus;
      bit          exp_fault;
      logic [31:0] exp_data;
      int          exp_cyc;
      int          cyc_n;
      int          lat;
      bus = ref_legal(f3) && (addr % ref_size(f3) == 0);
      if (!bus) begin
         exp_fault = 1'b1; exp_cyc = 0; exp_data = 32'd0;
      end else if (waits < int'(TO)) begin
         exp_cyc   = waits + 1;
         exp_fault = use_err;
         exp_data  = use_err ? 32'd0 : ref_data(f3, addr, dat);
      end else begin
         exp_cyc = int'(TO); exp_fault = 1'b1; exp_data = 32'd0;
      end

      req_i = 1'b1; addr_i = addr; funct3_i = f3; lat = 1;
      @(posedge clk_i); #1;
      req_i = 1'b0; lat = 2;
      chk({tag, " adr"}, 32'(adr_o), 32'(addr[31:2]));
      if (!bus) chk({tag, " no_cyc"}, 32'(cyc_o), 32'd0);

      cyc_n = 0;
      while (cyc_o === 1'b1 && cyc_n < 40) begin
         chk({tag, " sel"}, 32'(sel_o), 32'(ref_sel(f3, addr)));
         chk({tag, " stb"}, 32'(stb_o), 32'd1);
         chk({tag, " busy_bus"}, 32'(busy_o), 32'd1);
         if (cyc_n == waits) begin
            ack_i = !use_err || both_ack; err_i = use_err; dat_i = dat;
         end else begin
            ack_i = 1'b0; err_i = 1'b0; dat_i = $urandom;
         end
         req_i = 1'($urandom % 2); addr_i = $urandom; funct3_i = 3'($urandom);
         cyc_n++;
         @(posedge clk_i); #1;
         lat++;
         ack_i = 1'b0; err_i = 1'b0; req_i = 1'b0;
      end

      chk({tag, " cyc_cycles"}, 32'(cyc_n), 32'(exp_cyc));
      chk({tag, " done"}, 32'(done_o), 32'd1);
      chk({tag, " fault"}, 32'(fault_o), 32'(exp_fault));
      chk({tag, " data"}, data_o, exp_data);
      chk({tag, " latency"}, 32'(lat), bus ? 32'(exp_cyc + 2) : 32'd2);
      chk({tag, " busy_done"}, 32'(busy_o), 32'd1);
      chk({tag, " cyc_done"}, 32'(cyc_o), 32'd0);

      @(posedge clk_i); #1;
      chk({tag, " done_clr"}, 32'(done_o), 32'd0);
      chk({tag, " busy_clr"}, 32'(busy_o), 32'd0);
      chk({tag, " data_hold"}, data_o, exp_data);

      // Stray ack/err while idle must not start anything
      ack_i = 1'b1; err_i = 1'b1;
      @(posedge clk_i); #1;
      ack_i = 1'b0; err_i = 1'b0;
      chk({tag, " stray_ack"}, 32'({done_o, cyc_o, busy_o}), 32'd0);
   endtask

   initial begin
      logic [2:0]  rf3;
      logic [31:0] raddr;
      logic [31:0] rdat;
      int          rwaits;
      bit          rerr;
      bit          rboth;

      rst_i = 1'b1; req_i = 1'b0; addr_i = '0; funct3_i = '0;
      dat_i = '0; ack_i = 1'b0; err_i = 1'b0;
      #1;
      chk("rst cyc",   32'(cyc_o),   32'd0);
      chk("rst stb",   32'(stb_o),   32'd0);
      chk("rst busy",  32'(busy_o),  32'd0);
      chk("rst done",  32'(done_o),  32'd0);
      chk("rst fault", 32'(fault_o), 32'd0);
      chk("rst data",  data_o,       32'd0);
      chk("rst adr",   32'(adr_o),   32'd0);
      chk("rst sel",   32'(sel_o),   32'd0);
      chk("rst we",    32'(we_o),    32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      run_load("lb_1003",   3'b000, 32'h0000_1003, 32'h80AA_BBCC, 0, 1'b0, 1'b0);
      run_load("lhu_2002",  3'b101, 32'h0000_2002, 32'hBEEF_1234, 2, 1'b0, 1'b0);
      run_load("lh_mis",    3'b001, 32'h0000_2001, 32'h1111_1111, 0, 1'b0, 1'b0);
      run_load("lw_mis",    3'b010, 32'h0000_2002, 32'h2222_2222, 0, 1'b0, 1'b0);
      run_load("f3_011",    3'b011, 32'h0000_3000, 32'h3333_3333, 0, 1'b0, 1'b0);
      run_load("err_ack",   3'b010, 32'h0000_4000, 32'h4444_4444, 0, 1'b1, 1'b1);
      run_load("timeout",   3'b010, 32'h0000_5000, 32'h5555_5555, 99, 1'b0, 1'b0);
      run_load("lw_after",  3'b010, 32'h0000_5004, 32'hCAFE_F00D, 1, 1'b0, 1'b0);
      run_load("ack_at_to", 3'b000, 32'h0000_6001, 32'h0000_7F00, int'(TO) - 1, 1'b0, 1'b0);

      // Reset in the middle of a bus cycle drops the access silently
      req_i = 1'b1; addr_i = 32'h0000_7000; funct3_i = 3'b010;
      @(posedge clk_i); #1;
      req_i = 1'b0;
      chk("rstmid cyc1", 32'(cyc_o), 32'd1);
      @(posedge clk_i); #1;
      chk("rstmid cyc2", 32'(cyc_o), 32'd1);
      rst_i = 1'b1;
      #1;
      chk("rstmid cyc_drop", 32'(cyc_o), 32'd0);
      chk("rstmid stb_drop", 32'(stb_o), 32'd0);
      chk("rstmid busy",     32'(busy_o), 32'd0);
      chk("rstmid done",     32'(done_o), 32'd0);
      #2;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      chk("rstmid no_done1", 32'(done_o), 32'd0);
      @(posedge clk_i); #1;
      chk("rstmid no_done2", 32'(done_o), 32'd0);
      run_load("lbu_0", 3'b100, 32'h0000_0000, 32'h0000_00F0, 0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         rf3    = 3'($urandom % 8);
         raddr  = $urandom;
         if ($urandom % 2 == 0) raddr[1:0] = 2'b00;
         rdat   = $urandom;
         rwaits = int'($urandom % 6);
         rerr   = ($urandom % 8) == 0;
         rboth  = 1'($urandom % 2);
         run_load("rnd", rf3, raddr, rdat, rwaits, rerr, rboth);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_load_decode.md
Name: wb_load_decode

Overview:
Wishbone classic read initiator and load-data decoder for the core's load path; the receive-side counterpart of store-side byte-lane replication.
- Accepts one load request (byte address, RV32 funct3).
- Drives a single Wishbone read cycle with the correct byte selects and waits for ack/err, bounded by a timeout.
- Extracts the addressed byte, halfword or word from the 32-bit read bus, sign- or zero-extends it, and returns it registered with a one-cycle done pulse.

Parameters:
XLEN, 32, data width; only 32 is supported.
TIMEOUT, 255, maximum number of bus-wait cycles before the access is aborted with a fault; minimum 1.
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk_i  input  1  system clock, rising edge.
rst_i  input  1  asynchronous, active-high reset.
req_i  input  1  load request; sampled only when busy_o=0.
addr_i  input  32  byte address of the load.
funct3_i  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are illegal.
busy_o  output  1  high from the cycle after acceptance up to and including the done cycle.
done_o  output  1  one-cycle completion pulse.
fault_o  output  1  qualifies done_o: bus error, timeout, misalignment or illegal funct3.
data_o  output  32  decoded load result; valid while done_o=1 and held until the next done.
adr_o  output  30  Wishbone word address (addr_i[31:2]).
sel_o  output  4  Wishbone byte selects.
cyc_o  output  1  Wishbone cycle.
stb_o  output  1  Wishbone strobe.
we_o  output  1  tied to 0.
dat_i  input  32  Wishbone read data.
ack_i  input  1  Wishbone acknowledge.
err_i  input  1  Wishbone error.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - cyc_o, stb_o, busy_o, done_o, fault_o = 0.
  - data_o = 0, adr_o = 0, sel_o = 0.
  - State returns to IDLE; any in-flight access is dropped with no done pulse.
- States:
  - IDLE: if req_i=1, latch addr_i[1:0], funct3_i and adr_o.
    - Legal and aligned request -> BUS.
    - Misaligned or illegal request -> RESP_FAULT; no bus cycle is issued.
  - BUS: cyc_o = stb_o = 1; the timeout counter increments every cycle.
    - err_i=1 -> RESP_FAULT (err has priority over ack in the same cycle).
    - Otherwise ack_i=1 -> RESP_OK; dat_i is decoded and registered into data_o on that edge.
    - Otherwise, counter == TIMEOUT-1 -> RESP_FAULT.
    - If ack_i and timeout occur on the same cycle, ack wins.
  - RESP_OK: done_o=1, fault_o=0; cyc_o = stb_o = 0 -> IDLE.
  - RESP_FAULT: done_o=1, fault_o=1, data_o=0; cyc_o = stb_o = 0 -> IDLE.
- Latency:
  - Accept edge -> cyc_o high on the next cycle.
  - ack sampled on edge N -> done_o high during cycle N+1.
  - Minimum legal-load latency: 3 cycles from req to done, with a zero-wait slave.
  - Fault on misalignment/illegal funct3: done on the cycle after acceptance.
- Back-to-back: req_i is ignored while busy_o=1. A new request may be accepted in the cycle after done, when busy_o=0.
- Select generation (lane = addr[1:0]):
  - Byte: sel_o = 4'b0001 << lane.
  - Half: lane 0 -> 0011, lane 2 -> 1100.
  - Word: 1111.
  - sel_o is registered at acceptance and stable throughout the cycle.
- Misalignment:
  - Half with addr[0]=1.
  - Word with addr[1:0]!=0.
- Decode:
  - shifted = dat_i >> (8*lane).
  - LB = sign-extend shifted[7:0]; LBU = zero-extend shifted[7:0].
  - LH = sign-extend shifted[15:0]; LHU = zero-extend shifted[15:0].
  - LW = dat_i.
- The timeout counter clears on entry to BUS.
- ack_i/err_i arriving outside BUS are ignored.

Test Plan:
- LB at addr 0x1003, dat_i=0x80AABBCC, zero-wait ack -> sel_o=1000, adr_o=0x400; data_o=0xFFFFFF80, fault_o=0; done 3 cycles after req.
- LHU at 0x2002, dat_i=0xBEEF1234, 2 wait states -> sel_o=1100, data_o=0x0000BEEF; done 5 cycles after req.
- LH at 0x2001 and LW at 0x2002 -> cyc_o never asserted; done+fault on the next cycle; data_o=0.
- funct3_i=011 -> fault, no bus cycle. Separate case: err_i and ack_i high together on the first BUS cycle -> fault_o=1.
- Slave never acks, TIMEOUT=4 -> cyc_o high exactly 4 cycles, then done+fault; the next LW request is accepted normally with data_o=dat_i.
- rst_i pulsed on the 2nd BUS cycle -> cyc_o/stb_o drop the same cycle, no done_o; a subsequent LBU at 0x0 with dat_i=0x000000F0 returns 0x000000F0.
